id_stage: RTL

- Instruction-decode stage of the 5-stage MIPS pipeline. It sits between the IF/ID register and the ID/EX register.
- Contains the 32x32 architectural register file, the main and ALU decoders, the sign extender, and the early branch/jump resolution logic.
- Produces every D-suffixed control and data value the ID/EX register captures, plus the PC-select information for the fetch stage.

---
 rtl/id_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage: register file with write-through bypass, main/ALU decode,
// sign extension and early beq/j resolution for the fetch stage.
module id_stage #(
   parameter int REG_NUM = 32,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instrD,
   input  logic [DATA_W-1:0] pcPlus4D,
   input  logic              regWriteW,
   input  logic [4:0]        writeRegW,
   input  logic [DATA_W-1:0] resultW,
   input  logic [DATA_W-1:0] aluOutM,
   input  logic              forwardAD,
   input  logic              forwardBD,
   output logic              regWriteD,
   output logic              memToRegD,
   output logic              memWriteD,
   output logic              aluSrcD,
   output logic              regDstD,
   output logic [3:0]        aluCtrlD,
   output logic [4:0]        rsD,
   output logic [4:0]        rtD,
   output logic [4:0]        rdD,
   output logic [DATA_W-1:0] regData1D,
   output logic [DATA_W-1:0] regData2D,
   output logic [DATA_W-1:0] signExtImmD,
   output logic              branchD,
   output logic              pcSrcD,
   output logic [DATA_W-1:0] pcBranchD,
   output logic              jumpD,
   output logic [DATA_W-1:0] pcJumpD,
   output logic              illegalD
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_NOR = 6'b100111;

   logic [DATA_W-1:0] regs_r [REG_NUM];
   logic              wr_en_s;
   logic [5:0]        opcode_s;
   logic [5:0]        funct_s;
   logic [DATA_W-1:0] cmp_a_s;
   logic [DATA_W-1:0] cmp_b_s;

   assign opcode_s = instrD[31:26];
   assign funct_s  = instrD[5:0];
   assign rsD      = instrD[25:21];
   assign rtD      = instrD[20:16];
   assign rdD      = instrD[15:11];

   // r0 is never written, so its storage stays at the reset value of zero
   assign wr_en_s = rst && regWriteW && (writeRegW != 5'd0);

   // Register file storage, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs_r[i] <= '0;
         end
      end else if (wr_en_s) begin
         regs_r[writeRegW] <= resultW;
      end
   end

   // Read ports with same-cycle bypass of the writeback value
   always_comb begin
      regData1D = '0;
      regData2D = '0;
      if (wr_en_s && (writeRegW == rsD)) begin
         regData1D = resultW;
      end else if (rsD != 5'd0) begin
         regData1D = regs_r[rsD];
      end else begin
         regData1D = '0;
      end
      if (wr_en_s && (writeRegW == rtD)) begin
         regData2D = resultW;
      end else if (rtD != 5'd0) begin
         regData2D = regs_r[rtD];
      end else begin
         regData2D = '0;
      end
   end

   // Main and ALU decode; unknown encodings collapse to a bubble
   always_comb begin
      regWriteD = 1'b0;
      regDstD   = 1'b0;
      aluSrcD   = 1'b0;
      memWriteD = 1'b0;
      memToRegD = 1'b0;
      aluCtrlD  = 4'b0000;
      branchD   = 1'b0;
      jumpD     = 1'b0;
      illegalD  = 1'b0;
      case (opcode_s)
         OP_RTYPE: begin
            regWriteD = 1'b1;
            regDstD   = 1'b1;
            case (funct_s)
               FN_ADD:  aluCtrlD = 4'b0010;
               FN_SUB:  aluCtrlD = 4'b0110;
               FN_AND:  aluCtrlD = 4'b0000;
               FN_OR:   aluCtrlD = 4'b0001;
               FN_SLT:  aluCtrlD = 4'b0111;
               FN_NOR:  aluCtrlD = 4'b1100;
               default: begin
                  illegalD  = 1'b1;
                  regWriteD = 1'b0;
                  regDstD   = 1'b0;
                  aluCtrlD  = 4'b0000;
               end
            endcase
         end
         OP_LW: begin
            regWriteD = 1'b1;
            aluSrcD   = 1'b1;
            memToRegD = 1'b1;
            aluCtrlD  = 4'b0010;
         end
         OP_SW: begin
            aluSrcD   = 1'b1;
            memWriteD = 1'b1;
            aluCtrlD  = 4'b0010;
         end
         OP_BEQ: begin
            aluCtrlD = 4'b0110;
            branchD  = 1'b1;
         end
         OP_ADDI: begin
            regWriteD = 1'b1;
            aluSrcD   = 1'b1;
            aluCtrlD  = 4'b0010;
         end
         OP_J: begin
            jumpD = 1'b1;
         end
         default: begin
            illegalD = 1'b1;
         end
      endcase
   end

   assign signExtImmD = {{(DATA_W-16){instrD[15]}}, instrD[15:0]};
   assign pcBranchD   = pcPlus4D + {signExtImmD[DATA_W-3:0], 2'b00};
   assign pcJumpD     = {pcPlus4D[DATA_W-1:DATA_W-4], instrD[25:0], 2'b00};

   assign cmp_a_s = forwardAD ? aluOutM : regData1D;
   assign cmp_b_s = forwardBD ? aluOutM : regData2D;
   assign pcSrcD  = branchD && (cmp_a_s == cmp_b_s);

endmodule
